// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-control unit for the 5-stage ARMv8 pipeline.
// Computes per-operand EX forward selects, load-use bubbles, and the memory-wait / timeout FSM.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   ex_src             ID/EX operand indices, operand i = [i*ADDR_W +: ADDR_W]
//   id_src             IF/ID operand indices
//   id_src_valid       IF/ID operand i is actually read
//   id_ex_memread      instruction in EX is a load
//   id_ex_rd           EX destination
//   ex_mem_regwrite    EX/MEM writes a register
//   ex_mem_rd          EX/MEM destination
//   mem_wb_regwrite    MEM/WB writes a register
//   mem_wb_rd          MEM/WB destination
//   dmem_req           MEM stage accesses data memory this cycle
//   dmem_ready         data memory completes the access this cycle
//   fwd_sel            operand i = [2i+:2]: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_hold            PC and IF/ID hold
//   idex_flush         load a bubble into ID/EX
//   pipe_freeze        ID/EX, EX/MEM, MEM/WB hold
//   mem_timeout        sticky memory-timeout error
//   lu_stall_cnt       (FWD_PERF_CNT_EN) saturating count of bubble cycles
//   mem_stall_cnt      (FWD_PERF_CNT_EN) saturating count of freeze cycles
//
// Optional feature macro: FWD_PERF_CNT_EN adds the two performance counters.
module fwd_hazard_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 3,
    parameter int ZERO_REG = 31,
    parameter int TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_src,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_valid,
    input  logic                      id_ex_memread,
    input  logic [ADDR_W-1:0]         id_ex_rd,
    input  logic                      ex_mem_regwrite,
    input  logic [ADDR_W-1:0]         ex_mem_rd,
    input  logic                      mem_wb_regwrite,
    input  logic [ADDR_W-1:0]         mem_wb_rd,
    input  logic                      dmem_req,
    input  logic                      dmem_ready,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      pc_hold,
    output logic                      idex_flush,
    output logic                      pipe_freeze,
    output logic                      mem_timeout
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]               lu_stall_cnt,
    output logic [31:0]               mem_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;

    logic               exm_live;
    logic               mwb_live;
    logic               lu;
    logic               hold_raw;
    logic               flush_raw;
    logic               freeze_raw;
    logic [2*NUM_SRC-1:0] fwd_raw;

    // XZR destinations never produce a value worth forwarding.
    assign exm_live = ex_mem_regwrite && (ex_mem_rd != ZR);
    assign mwb_live = mem_wb_regwrite && (mem_wb_rd != ZR);

    // EX/MEM is the younger producer, so it is tested first.
    always_comb begin
        fwd_raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exm_live && (ex_mem_rd == ex_src[i*ADDR_W +: ADDR_W])) begin
                fwd_raw[2*i +: 2] = 2'b10;
            end else if (mwb_live && (mem_wb_rd == ex_src[i*ADDR_W +: ADDR_W])) begin
                fwd_raw[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid[i] && (id_src[i*ADDR_W +: ADDR_W] == id_ex_rd)) begin
                lu = 1'b1;
            end
        end
        lu = lu && id_ex_memread && (id_ex_rd != ZR);
    end

    // Stall outputs are Mealy: they react to this cycle's inputs.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        hold_raw      = 1'b0;
        flush_raw     = 1'b0;
        freeze_raw    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    hold_raw   = 1'b1;
                    freeze_raw = 1'b1;
                    state_d    = S_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else if (lu) begin
                    hold_raw  = 1'b1;
                    flush_raw = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    // Completing access: behave as RUN, new requests ignored.
                    if (lu) begin
                        hold_raw  = 1'b1;
                        flush_raw = 1'b1;
                    end
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else begin
                    hold_raw   = 1'b1;
                    freeze_raw = 1'b1;
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                    if (wait_cnt_q == CNT_LAST) begin
                        mem_timeout_d = 1'b1;
                        state_d       = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                hold_raw   = 1'b1;
                freeze_raw = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Everything is forced quiet while reset is held.
    assign fwd_sel     = reset ? '0 : fwd_raw;
    assign pc_hold     = hold_raw && !reset;
    assign idex_flush  = flush_raw && !reset;
    assign pipe_freeze = freeze_raw && !reset;
    assign mem_timeout = mem_timeout_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] mem_cnt_q, mem_cnt_d;

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if (idex_flush && (lu_cnt_q != 32'hFFFF_FFFF)) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
        if (pipe_freeze && (mem_cnt_q != 32'hFFFF_FFFF)) begin
            mem_cnt_d = mem_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fwd_hazard_unit;

    localparam int ADDR_W   = 5;
    localparam int NUM_SRC  = 3;
    localparam int ZERO_REG = 31;
    localparam int TIMEOUT  = 8;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_SRC*ADDR_W-1:0] ex_src;
    logic [NUM_SRC*ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_valid;
    logic                      id_ex_memread;
    logic [ADDR_W-1:0]         id_ex_rd;
    logic                      ex_mem_regwrite;
    logic [ADDR_W-1:0]         ex_mem_rd;
    logic                      mem_wb_regwrite;
    logic [ADDR_W-1:0]         mem_wb_rd;
    logic                      dmem_req;
    logic                      dmem_ready;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      pc_hold;
    logic                      idex_flush;
    logic                      pipe_freeze;
    logic                      mem_timeout;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]               lu_stall_cnt;
    logic [31:0]               mem_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 0;

    // Behavioural model state
    int     stall_run = 0;   // consecutive not-ready memory stall cycles so far
    bit     faulted = 0;
    longint lu_cnt_m = 0;
    longint mem_cnt_m = 0;
    bit     mh, mf, mz;

    fwd_hazard_unit #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
        .ZERO_REG(ZERO_REG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .ex_src(ex_src), .id_src(id_src), .id_src_valid(id_src_valid),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_sel(fwd_sel), .pc_hold(pc_hold), .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout)
`ifdef FWD_PERF_CNT_EN
        , .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] pk(input int a, input int b, input int c);
        logic [4:0] x, y, z;
        x = 5'(a); y = 5'(b); z = 5'(c);
        return {z, y, x};
    endfunction

    function automatic int op(input logic [14:0] v, input int i);
        return int'((v >> (i * ADDR_W)) & 15'h1F);
    endfunction

    // Forward source priority: the younger producer (EX/MEM) first.
    function automatic logic [5:0] fwd_model();
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            int s;
            s = op(ex_src, i);
            if (ex_mem_regwrite && int'(ex_mem_rd) != ZERO_REG && int'(ex_mem_rd) == s)
                r = r | (6'd2 << (2 * i));
            else if (mem_wb_regwrite && int'(mem_wb_rd) != ZERO_REG && int'(mem_wb_rd) == s)
                r = r | (6'd1 << (2 * i));
        end
        return r;
    endfunction

    function automatic bit lu_model();
        bit hit;
        hit = 0;
        for (int i = 0; i < NUM_SRC; i++)
            if (id_src_valid[i] && op(id_src, i) == int'(id_ex_rd)) hit = 1;
        return hit && id_ex_memread && int'(id_ex_rd) != ZERO_REG;
    endfunction

    function automatic void stall_model(output bit h, output bit f, output bit z);
        h = 0; f = 0; z = 0;
        if (faulted) begin
            h = 1; z = 1;
        end else if (stall_run > 0) begin
            if (dmem_ready) begin
                if (lu_model()) begin h = 1; f = 1; end
            end else begin
                h = 1; z = 1;
            end
        end else if (dmem_req && !dmem_ready) begin
            h = 1; z = 1;
        end else if (lu_model()) begin
            h = 1; f = 1;
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            stall_run = 0; faulted = 0; lu_cnt_m = 0; mem_cnt_m = 0;
        end else begin
            bit h, f, z;
            stall_model(h, f, z);
            if (f) lu_cnt_m++;
            if (z) mem_cnt_m++;
            if (faulted) begin
            end else if (stall_run > 0) begin
                if (dmem_ready) stall_run = 0;
                else begin
                    stall_run++;
                    if (stall_run >= TIMEOUT) begin
                        faulted = 1; stall_run = 0;
                    end
                end
            end else if (dmem_req && !dmem_ready) begin
                stall_run = 1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (check_en) begin
            if (reset) begin
                chk("rst_fwd_sel", fwd_sel, 0);
                chk("rst_pc_hold", pc_hold, 0);
                chk("rst_idex_flush", idex_flush, 0);
                chk("rst_pipe_freeze", pipe_freeze, 0);
                chk("rst_mem_timeout", mem_timeout, 0);
            end else begin
                stall_model(mh, mf, mz);
                chk("fwd_sel", fwd_sel, fwd_model());
                chk("pc_hold", pc_hold, mh);
                chk("idex_flush", idex_flush, mf);
                chk("pipe_freeze", pipe_freeze, mz);
                chk("mem_timeout", mem_timeout, faulted);
`ifdef FWD_PERF_CNT_EN
                chk("lu_stall_cnt", lu_stall_cnt, lu_cnt_m);
                chk("mem_stall_cnt", mem_stall_cnt, mem_cnt_m);
`endif
            end
        end
    end

    task automatic idle();
        ex_src = '0; id_src = '0; id_src_valid = '0;
        id_ex_memread = 0; id_ex_rd = '0;
        ex_mem_regwrite = 0; ex_mem_rd = '0;
        mem_wb_regwrite = 0; mem_wb_rd = '0;
        dmem_req = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; idle();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic lu_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd5;
        id_src = pk(0, 5, 0); id_src_valid = 3'b010;
    endtask

    function automatic logic [4:0] rnd_idx();
        int r;
        r = $urandom_range(0, 9);
        return (r == 9) ? 5'd31 : 5'(r % 4);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        do_reset();
        check_en = 1;

        // 1: EX/MEM beats MEM/WB, then MEM/WB alone
        ex_mem_regwrite = 1; ex_mem_rd = 5'd3;
        mem_wb_regwrite = 1; mem_wb_rd = 5'd3;
        ex_src = pk(3, 0, 0);
        #3 chk("t1_exmem", fwd_sel, 6'b000010);
        @(negedge clk); ex_mem_regwrite = 0;
        #3 chk("t1_memwb", fwd_sel, 6'b000001);

        // 2: XZR never forwards nor stalls
        @(negedge clk); idle();
        ex_mem_regwrite = 1; ex_mem_rd = 5'd31; ex_src = pk(0, 31, 0);
        id_ex_memread = 1; id_ex_rd = 5'd31;
        id_src = pk(31, 0, 0); id_src_valid = 3'b001;
        #3 chk("t2_xzr_fwd", fwd_sel[3:2], 2'b00);
        chk("t2_xzr_hold", pc_hold, 0);
        chk("t2_xzr_flush", idex_flush, 0);

        // 3: single load-use bubble, then invalid operand
        @(negedge clk); idle(); lu_inputs();
        #3 chk("t3_lu_hold", pc_hold, 1);
        chk("t3_lu_flush", idex_flush, 1);
        chk("t3_lu_freeze", pipe_freeze, 0);
        @(negedge clk); id_ex_memread = 0;
        #3 chk("t3_after_hold", pc_hold, 0);
        chk("t3_after_flush", idex_flush, 0);
        @(negedge clk); lu_inputs(); id_src_valid = 3'b000;
        #3 chk("t3_noval_hold", pc_hold, 0);

        // 4: 4-cycle memory wait with concurrent load-use
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); idle(); lu_inputs();
            dmem_req = 1; dmem_ready = 0;
            #3 chk("t4_wait_hold", pc_hold, 1);
            chk("t4_wait_freeze", pipe_freeze, 1);
            chk("t4_wait_flush", idex_flush, 0);
        end
        @(negedge clk); dmem_ready = 1;
        #3 chk("t4_ready_hold", pc_hold, 1);
        chk("t4_ready_flush", idex_flush, 1);
        chk("t4_ready_freeze", pipe_freeze, 0);
        @(negedge clk); idle();
        #3 chk("t4_idle_hold", pc_hold, 0);
`ifdef FWD_PERF_CNT_EN
        chk("t6_lu_cnt", lu_stall_cnt, 2);
        chk("t6_mem_cnt", mem_stall_cnt, 4);
`endif

        // 5: timeout after TIMEOUT stall cycles, then reset while faulted
        do_reset();
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk); dmem_req = 1; dmem_ready = 0;
            #3 chk("t5_stall_hold", pc_hold, 1);
            chk("t5_stall_timeout", mem_timeout, 0);
        end
        @(negedge clk);
        #3 chk("t5_timeout", mem_timeout, 1);
        chk("t5_fault_freeze", pipe_freeze, 1);
        @(negedge clk); dmem_req = 0; dmem_ready = 1;
        ex_mem_regwrite = 1; ex_mem_rd = 5'd3; ex_src = pk(3, 0, 0);
        #3 chk("t5_fault_hold", pc_hold, 1);
        chk("t5_fault_fwd", fwd_sel, 6'b000010);
        #1 reset = 1;
        #1 chk("t5_rst_hold", pc_hold, 0);
        chk("t5_rst_freeze", pipe_freeze, 0);
        chk("t5_rst_timeout", mem_timeout, 0);
        chk("t5_rst_fwd", fwd_sel, 0);
        @(negedge clk); idle();
        @(negedge clk); reset = 0;

        // reset in the middle of a wait
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); dmem_req = 1; dmem_ready = 0;
        end
        #4 reset = 1;
        #1 chk("t5_midwait_hold", pc_hold, 0);
        chk("t5_midwait_freeze", pipe_freeze, 0);
        @(negedge clk); idle();
        @(negedge clk); reset = 0;
        #3 chk("t5_post_hold", pc_hold, 0);
        chk("t5_post_timeout", mem_timeout, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (reset) reset = 0;
            else if (faulted && $urandom_range(0, 3) == 0) reset = 1;
            for (int i = 0; i < NUM_SRC; i++) begin
                ex_src[i*ADDR_W +: ADDR_W] = rnd_idx();
                id_src[i*ADDR_W +: ADDR_W] = rnd_idx();
            end
            id_src_valid = 3'($urandom_range(0, 7));
            id_ex_memread = ($urandom_range(0, 2) == 0);
            id_ex_rd = rnd_idx();
            ex_mem_regwrite = $urandom_range(0, 1) == 1;
            ex_mem_rd = rnd_idx();
            mem_wb_regwrite = $urandom_range(0, 1) == 1;
            mem_wb_rd = rnd_idx();
            dmem_req = ($urandom_range(0, 9) < 3);
            dmem_ready = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
